mips_cpu_harvard_lsu: RTL

Load/store unit on the CPU (initiator) side of the Harvard data-memory port. It accepts one MIPS load or store per request from the execute stage and converts it into word-aligned reads and writes on the data port. The data port has combinational read and single-cycle write. Sub-word stores use a read-modify-write sequence. The unit returns sign- or zero-extended or merged load results to writeback, big-endian (byte offset 0 = bits [31:24]).

---
 rtl/mips_cpu_harvard_lsu_if.sv | 40 ++++
 rtl/mips_cpu_harvard_lsu.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/mips_cpu_harvard_lsu_if.sv
`default_nettype none
// ============================================================================
//  Module   : mips_cpu_harvard_lsu_if
//  Purpose  : Groups the execute-stage request, the writeback response and the
//             Harvard data-memory port of the load/store unit.
//             slave  = the LSU side, master = the execute stage / memory side.
//  Revision : 1.0  initial release
// ============================================================================
interface mips_cpu_harvard_lsu_if;
  // Request from execute
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_rt;
  // Response to writeback
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_data;
  // Data-memory port
  logic [31:0] data_address;
  logic        data_read;
  logic        data_write;
  logic [31:0] data_writedata;
  logic [31:0] data_readdata;

  modport slave (
    input  req_valid, req_write, req_op, req_addr, req_rt, data_readdata,
    output req_ready, resp_valid, resp_err, resp_data,
           data_address, data_read, data_write, data_writedata
  );

  modport master (
    output req_valid, req_write, req_op, req_addr, req_rt, data_readdata,
    input  req_ready, resp_valid, resp_err, resp_data,
           data_address, data_read, data_write, data_writedata
  );
endinterface
`default_nettype wire

// File: rtl/mips_cpu_harvard_lsu.sv
`default_nettype none
// ============================================================================
//  Module   : mips_cpu_harvard_lsu
//  Purpose  : MIPS load/store unit for a Harvard data port with combinational
//             read and single-cycle write. Sub-word stores are done as
//             read-modify-write. Big-endian: byte offset 0 is bits [31:24].
//  Revision : 1.0  initial release
// ============================================================================
module mips_cpu_harvard_lsu (
  input  wire                          clk,
  input  wire                          reset,
  input  wire                          clk_enable,
  mips_cpu_harvard_lsu_if.slave        bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2,
    S_RESP = 2'd3
  } state_t;

  localparam logic [2:0] c_OP_B   = 3'b000;
  localparam logic [2:0] c_OP_H   = 3'b001;
  localparam logic [2:0] c_OP_WL  = 3'b010;
  localparam logic [2:0] c_OP_W   = 3'b011;
  localparam logic [2:0] c_OP_BU  = 3'b100;
  localparam logic [2:0] c_OP_HU  = 3'b101;
  localparam logic [2:0] c_OP_WR  = 3'b110;
  localparam logic [2:0] c_OP_BAD = 3'b111;

  state_t      r_state;
  logic        r_write;
  logic [2:0]  r_op;
  logic [1:0]  r_off;
  logic [31:0] r_rt;

  logic        r_req_ready;
  logic        r_resp_valid;
  logic        r_resp_err;
  logic [31:0] r_resp_data;
  logic [31:0] r_data_address;
  logic        r_data_read;
  logic        r_wr_phase;
  logic [31:0] r_data_writedata;

  logic        w_is_half;
  logic        w_is_word;
  logic        w_op_bad;
  logic        w_req_err;
  logic        w_req_sw;

  logic [4:0]  w_sh_b;
  logic [4:0]  w_sh_h;
  logic [31:0] w_rd_b;
  logic [31:0] w_rd_h;
  logic [31:0] w_load_data;
  logic [31:0] w_merged;

  // Classify the incoming request: alignment and opcode legality
  always_comb begin
    w_is_half = (bus.req_op[1:0] == 2'b01);
    w_is_word = (bus.req_op == c_OP_W);
    if (bus.req_write) begin
      w_op_bad = !((bus.req_op == c_OP_B) || (bus.req_op == c_OP_H) ||
                   (bus.req_op == c_OP_W));
    end else begin
      w_op_bad = (bus.req_op == c_OP_BAD);
    end
    w_req_err = w_op_bad |
                (w_is_half & bus.req_addr[0]) |
                (w_is_word & (bus.req_addr[1:0] != 2'b00));
    w_req_sw  = bus.req_write & (bus.req_op == c_OP_W);
  end

  // Byte-lane shift amounts; big-endian means byte k sits 8*(3-k) bits up
  always_comb begin
    w_sh_b = {~r_off, 3'b000};
    w_sh_h = {~r_off[1], 4'b0000};
    w_rd_b = bus.data_readdata >> w_sh_b;
    w_rd_h = bus.data_readdata >> w_sh_h;
  end

  // Load result formation from the combinational read word
  always_comb begin
    w_load_data = 32'h0000_0000;
    case (r_op)
      c_OP_B:  w_load_data = {{24{w_rd_b[7]}}, w_rd_b[7:0]};
      c_OP_BU: w_load_data = {24'h00_0000, w_rd_b[7:0]};
      c_OP_H:  w_load_data = {{16{w_rd_h[15]}}, w_rd_h[15:0]};
      c_OP_HU: w_load_data = {16'h0000, w_rd_h[15:0]};
      c_OP_W:  w_load_data = bus.data_readdata;
      // lwl: memory bytes k..3 move to the top, rt keeps its low k bytes
      c_OP_WL: w_load_data = (bus.data_readdata << {r_off, 3'b000}) |
                             (r_rt & ~(32'hFFFF_FFFF << {r_off, 3'b000}));
      // lwr: memory bytes 0..k move to the bottom, rt keeps its high 3-k bytes
      c_OP_WR: w_load_data = (bus.data_readdata >> w_sh_b) |
                             (r_rt & ~(32'hFFFF_FFFF >> w_sh_b));
      default: w_load_data = 32'h0000_0000;
    endcase
  end

  // Sub-word store merge into the old word fetched in RD
  always_comb begin
    if (r_op == c_OP_B) begin
      w_merged = (bus.data_readdata & ~(32'h0000_00FF << w_sh_b)) |
                 ({24'h00_0000, r_rt[7:0]} << w_sh_b);
    end else begin
      w_merged = (bus.data_readdata & ~(32'h0000_FFFF << w_sh_h)) |
                 ({16'h0000, r_rt[15:0]} << w_sh_h);
    end
  end

  // Control FSM with registered outputs; clk_enable low freezes everything
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state          <= S_IDLE;
      r_write          <= 1'b0;
      r_op             <= 3'b000;
      r_off            <= 2'b00;
      r_rt             <= 32'h0000_0000;
      r_req_ready      <= 1'b1;
      r_resp_valid     <= 1'b0;
      r_resp_err       <= 1'b0;
      r_resp_data      <= 32'h0000_0000;
      r_data_address   <= 32'h0000_0000;
      r_data_read      <= 1'b0;
      r_wr_phase       <= 1'b0;
      r_data_writedata <= 32'h0000_0000;
    end else if (clk_enable) begin
      case (r_state)
        S_IDLE: begin
          if (bus.req_valid) begin
            r_write     <= bus.req_write;
            r_op        <= bus.req_op;
            r_off       <= bus.req_addr[1:0];
            r_rt        <= bus.req_rt;
            r_req_ready <= 1'b0;
            if (w_req_err) begin
              r_state      <= S_RESP;
              r_resp_valid <= 1'b1;
              r_resp_err   <= 1'b1;
              r_resp_data  <= 32'h0000_0000;
            end else if (w_req_sw) begin
              r_state          <= S_WR;
              r_data_address   <= {bus.req_addr[31:2], 2'b00};
              r_wr_phase       <= 1'b1;
              r_data_writedata <= bus.req_rt;
            end else begin
              r_state        <= S_RD;
              r_data_address <= {bus.req_addr[31:2], 2'b00};
              r_data_read    <= 1'b1;
            end
          end
        end
        S_RD: begin
          r_data_read <= 1'b0;
          if (r_write) begin
            r_state          <= S_WR;
            r_wr_phase       <= 1'b1;
            r_data_writedata <= w_merged;
          end else begin
            r_state        <= S_RESP;
            r_data_address <= 32'h0000_0000;
            r_resp_valid   <= 1'b1;
            r_resp_data    <= w_load_data;
          end
        end
        S_WR: begin
          r_state          <= S_RESP;
          r_wr_phase       <= 1'b0;
          r_data_writedata <= 32'h0000_0000;
          r_data_address   <= 32'h0000_0000;
          r_resp_valid     <= 1'b1;
          r_resp_data      <= 32'h0000_0000;
        end
        S_RESP: begin
          r_state      <= S_IDLE;
          r_req_ready  <= 1'b1;
          r_resp_valid <= 1'b0;
          r_resp_err   <= 1'b0;
          r_resp_data  <= 32'h0000_0000;
        end
        default: begin
          r_state     <= S_IDLE;
          r_req_ready <= 1'b1;
        end
      endcase
    end
  end

  assign bus.req_ready      = r_req_ready;
  assign bus.resp_valid     = r_resp_valid;
  assign bus.resp_err       = r_resp_err;
  assign bus.resp_data      = r_resp_data;
  assign bus.data_address   = r_data_address;
  assign bus.data_read      = r_data_read;
  // Gated so a stalled or reset-aborted WR cycle cannot commit a write
  assign bus.data_write     = r_wr_phase & clk_enable & ~reset;
  assign bus.data_writedata = r_data_writedata;

endmodule
`default_nettype wire
